acc_readout_scheduler: RTL and testbench

Round-robin scheduler that time-shares the single serial readout pin between the per-channel accumulator results (SA I, SA Q, CML I, CML Q). It runs on one clock, grants one ready channel at a time, and emits a framed word on `serialOut` with a one-cycle `serialStart` marker. It sits between the accumulator bank and the `serialStart`/`serialOut` output pads.

---
 rtl/acc_readout_scheduler_if.sv | 27 ++
 rtl/acc_readout_scheduler.sv | 135 +++++++++++++
 tb/tb_acc_readout_scheduler.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/acc_readout_scheduler_if.sv
// Bundle between the accumulator bank / output pads and the readout scheduler.
// The scheduler takes the master modport; the accumulator/pad side takes slave.
interface acc_readout_scheduler_if #(
    parameter int ACC_WIDTH = 16,
    parameter int NUM_CH    = 4
);
    localparam int ID_W = $clog2(NUM_CH);

    logic                        enable;
    logic [NUM_CH-1:0]           ch_valid;
    logic [NUM_CH*ACC_WIDTH-1:0] ch_data;
    logic [NUM_CH-1:0]           ch_ack;
    logic                        serialStart;
    logic                        serialOut;
    logic                        busy;
    logic [ID_W-1:0]             last_id;

    modport master (
        input  enable, ch_valid, ch_data,
        output ch_ack, serialStart, serialOut, busy, last_id
    );

    modport slave (
        output enable, ch_valid, ch_data,
        input  ch_ack, serialStart, serialOut, busy, last_id
    );
endinterface

// File: rtl/acc_readout_scheduler.sv
// Round-robin readout scheduler: grants one ready accumulator channel at a time
// and serialises {channel id, data} MSB-first behind a one-cycle start marker.
module acc_readout_scheduler #(
    parameter int ACC_WIDTH = 16,
    parameter int NUM_CH    = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    acc_readout_scheduler_if.master  bus
);
    localparam int ID_W  = $clog2(NUM_CH);
    localparam int F     = ID_W + ACC_WIDTH;
    localparam int CNT_W = $clog2(F);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    state_t             r_state;
    logic [ID_W-1:0]    r_rr_ptr;
    logic [ID_W-1:0]    r_last_id;
    logic [F-1:0]       r_shreg;
    logic [CNT_W-1:0]   r_bitcnt;
    logic [NUM_CH-1:0]  r_ch_ack;
    logic               r_serial_start;
    logic               r_serial_out;
    logic               r_busy;

    logic               w_found;
    logic [ID_W-1:0]    w_winner;
    logic [ID_W-1:0]    w_idx;
    logic [ACC_WIDTH-1:0] w_data;
    logic [F-1:0]       w_frame;
    logic [NUM_CH-1:0]  w_onehot;

    // Round-robin search: first valid channel at or after the pointer, wrapping.
    always_comb begin
        w_found  = 1'b0;
        w_winner = r_rr_ptr;
        w_idx    = r_rr_ptr;
        for (int k = 0; k < NUM_CH; k++) begin
            w_idx = r_rr_ptr + ID_W'(k);
            if (!w_found && bus.ch_valid[w_idx]) begin
                w_found  = 1'b1;
                w_winner = w_idx;
            end else begin
            end
        end
    end

    // Winner data mux with constant part-selects.
    always_comb begin
        w_data = {ACC_WIDTH{1'b0}};
        for (int i = 0; i < NUM_CH; i++) begin
            if (w_winner == ID_W'(i)) begin
                w_data = bus.ch_data[i*ACC_WIDTH +: ACC_WIDTH];
            end else begin
            end
        end
    end

    assign w_frame  = {w_winner, w_data};
    assign w_onehot = NUM_CH'(1) << w_winner;

    // Scheduler FSM; serial output register always holds the bit currently on the pin.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state        <= S_IDLE;
            r_rr_ptr       <= {ID_W{1'b0}};
            r_last_id      <= {ID_W{1'b0}};
            r_shreg        <= {F{1'b0}};
            r_bitcnt       <= {CNT_W{1'b0}};
            r_ch_ack       <= {NUM_CH{1'b0}};
            r_serial_start <= 1'b0;
            r_serial_out   <= 1'b0;
            r_busy         <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.enable && w_found) begin
                        r_shreg        <= w_frame;
                        r_serial_out   <= w_frame[F-1];
                        r_ch_ack       <= w_onehot;
                        r_last_id      <= w_winner;
                        r_rr_ptr       <= w_winner + ID_W'(1);
                        r_bitcnt       <= CNT_W'(F - 1);
                        r_serial_start <= 1'b1;
                        r_busy         <= 1'b1;
                        r_state        <= S_SHIFT;
                    end else begin
                        r_ch_ack       <= {NUM_CH{1'b0}};
                        r_serial_start <= 1'b0;
                        r_serial_out   <= 1'b0;
                        r_busy         <= 1'b0;
                    end
                end
                S_SHIFT: begin
                    r_ch_ack       <= {NUM_CH{1'b0}};
                    r_serial_start <= 1'b0;
                    r_shreg        <= r_shreg << 1;
                    if (r_bitcnt == CNT_W'(0)) begin
                        r_serial_out <= 1'b0;
                        r_state      <= S_GAP;
                    end else begin
                        // Bit MSB-1 becomes the MSB after this shift.
                        r_serial_out <= r_shreg[F-2];
                        r_bitcnt     <= r_bitcnt - CNT_W'(1);
                    end
                end
                S_GAP: begin
                    r_ch_ack       <= {NUM_CH{1'b0}};
                    r_serial_start <= 1'b0;
                    r_serial_out   <= 1'b0;
                    r_busy         <= 1'b0;
                    r_state        <= S_IDLE;
                end
                default: begin
                    r_ch_ack       <= {NUM_CH{1'b0}};
                    r_serial_start <= 1'b0;
                    r_serial_out   <= 1'b0;
                    r_busy         <= 1'b0;
                    r_state        <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.ch_ack      = r_ch_ack;
    assign bus.serialStart = r_serial_start;
    assign bus.serialOut   = r_serial_out;
    assign bus.busy        = r_busy;
    assign bus.last_id     = r_last_id;
endmodule

// File: tb/tb_acc_readout_scheduler.sv
// Directed bench: table of single-grant frames (round robin, pointer skip,
// back-to-back period) plus sequences for enable gating, reset mid-frame, 2-channel build.
module tb_acc_readout_scheduler;
    logic clk;
    logic rst;
    logic rst2;
    int   checks;
    int   errors;
    int   cyc;
    int   last_start;

    acc_readout_scheduler_if #(.ACC_WIDTH(16), .NUM_CH(4)) bus ();
    acc_readout_scheduler_if #(.ACC_WIDTH(4),  .NUM_CH(2)) bus2 ();

    acc_readout_scheduler #(.ACC_WIDTH(16), .NUM_CH(4)) dut (
        .clk   (clk),
        .reset (rst),
        .bus   (bus)
    );

    acc_readout_scheduler #(.ACC_WIDTH(4), .NUM_CH(2)) dut2 (
        .clk   (clk),
        .reset (rst2),
        .bus   (bus2)
    );

    typedef struct {
        logic [3:0]  mask;
        int          id;
        logic [17:0] frame;
        bit          chk_period;
    } vec_t;

    vec_t vecs[11];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Request mask at a negedge, then verify ack, every frame bit, gap and return to idle.
    task automatic run_frame(input logic [3:0] mask, input logic [3:0] after, input int drop_at,
                             input int id, input logic [17:0] exp, input bit chk_period,
                             input string nm);
        logic [17:0] got;
        bus.ch_valid = mask;
        @(negedge clk);
        check({nm, " ack"}, 32'(bus.ch_ack), 32'd1 << id);
        check({nm, " start"}, 32'(bus.serialStart), 32'd1);
        check({nm, " busy"}, 32'(bus.busy), 32'd1);
        check({nm, " last_id"}, 32'(bus.last_id), 32'(id));
        if (chk_period) check({nm, " period"}, 32'(cyc - last_start), 32'd20);
        last_start = cyc;
        bus.ch_valid = after;
        got = '0;
        got[17] = bus.serialOut;
        for (int k = 1; k < 18; k++) begin
            @(negedge clk);
            if (k == drop_at) bus.enable = 1'b0;
            got[17-k] = bus.serialOut;
            if (k == 1) begin
                check({nm, " start_1cyc"}, 32'(bus.serialStart), 32'd0);
                check({nm, " ack_1cyc"}, 32'(bus.ch_ack), 32'd0);
            end
        end
        check({nm, " frame"}, 32'(got), 32'(exp));
        @(negedge clk);
        check({nm, " gap_out"}, 32'(bus.serialOut), 32'd0);
        check({nm, " gap_busy"}, 32'(bus.busy), 32'd1);
        @(negedge clk);
        check({nm, " idle_busy"}, 32'(bus.busy), 32'd0);
        check({nm, " idle_out"}, 32'(bus.serialOut), 32'd0);
    endtask

    initial begin
        logic [4:0] got5;
        logic [4:0] exp5;
        int         w;
        int         prev2;
        checks = 0;
        errors = 0;
        cyc = 0;
        last_start = 0;
        prev2 = 0;

        vecs[0]  = '{4'b0100, 2, 18'h2A5C3, 1'b0};
        vecs[1]  = '{4'b1111, 3, 18'h30F0F, 1'b1};
        vecs[2]  = '{4'b1111, 0, 18'h01234, 1'b1};
        vecs[3]  = '{4'b1111, 1, 18'h1BEEF, 1'b1};
        vecs[4]  = '{4'b1111, 2, 18'h2A5C3, 1'b1};
        vecs[5]  = '{4'b1111, 3, 18'h30F0F, 1'b1};
        vecs[6]  = '{4'b1111, 0, 18'h01234, 1'b1};
        vecs[7]  = '{4'b0010, 1, 18'h1BEEF, 1'b1};
        vecs[8]  = '{4'b1001, 3, 18'h30F0F, 1'b1};
        vecs[9]  = '{4'b1001, 0, 18'h01234, 1'b1};
        vecs[10] = '{4'b0001, 0, 18'h01234, 1'b1};

        rst  = 1'b1;
        rst2 = 1'b1;
        bus.enable   = 1'b1;
        bus.ch_valid = 4'b0000;
        bus.ch_data  = {16'h0F0F, 16'hA5C3, 16'hBEEF, 16'h1234};
        bus2.enable   = 1'b0;
        bus2.ch_valid = 2'b00;
        bus2.ch_data  = {4'hF, 4'h6};

        repeat (3) @(negedge clk);
        check("reset ack", 32'(bus.ch_ack), 32'd0);
        check("reset start", 32'(bus.serialStart), 32'd0);
        check("reset out", 32'(bus.serialOut), 32'd0);
        check("reset busy", 32'(bus.busy), 32'd0);
        check("reset last_id", 32'(bus.last_id), 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 11; i++) begin
            run_frame(vecs[i].mask, 4'b0000, -1, vecs[i].id, vecs[i].frame,
                      vecs[i].chk_period, $sformatf("vec%0d", i));
        end

        // Enable dropped mid-frame while channel 2 requests.
        run_frame(4'b0001, 4'b0100, 5, 0, 18'h01234, 1'b1, "en_drop");
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("en_off ack", 32'(bus.ch_ack), 32'd0);
            check("en_off busy", 32'(bus.busy), 32'd0);
            check("en_off out", 32'(bus.serialOut), 32'd0);
        end
        bus.enable = 1'b1;
        run_frame(4'b0100, 4'b0000, -1, 2, 18'h2A5C3, 1'b0, "en_back");

        // Reset asserted between clock edges while frame bit 7 (a 1) is on the pin.
        bus.ch_valid = 4'b1000;
        @(negedge clk);
        check("rstmid ack", 32'(bus.ch_ack), 32'b1000);
        bus.ch_valid = 4'b0000;
        repeat (7) @(negedge clk);
        check("rstmid pre busy", 32'(bus.busy), 32'd1);
        check("rstmid pre bit7", 32'(bus.serialOut), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("rstmid out", 32'(bus.serialOut), 32'd0);
        check("rstmid busy", 32'(bus.busy), 32'd0);
        check("rstmid start", 32'(bus.serialStart), 32'd0);
        check("rstmid ackz", 32'(bus.ch_ack), 32'd0);
        check("rstmid last_id", 32'(bus.last_id), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        run_frame(4'b1001, 4'b0000, -1, 0, 18'h01234, 1'b0, "post_rst");

        // Two-channel, 4-bit build with both channels held valid throughout.
        rst2 = 1'b0;
        bus2.enable   = 1'b1;
        bus2.ch_valid = 2'b11;
        for (int f = 0; f < 4; f++) begin
            w = 0;
            @(negedge clk);
            while (!bus2.serialStart && w < 20) begin
                @(negedge clk);
                w++;
            end
            check("p2 start_seen", 32'(bus2.serialStart), 32'd1);
            check("p2 ack", 32'(bus2.ch_ack), 32'd1 << (f % 2));
            if (f > 0) check("p2 period", 32'(cyc - prev2), 32'd7);
            prev2 = cyc;
            exp5 = (f % 2 == 1) ? 5'b11111 : 5'b00110;
            got5[4] = bus2.serialOut;
            for (int k = 1; k < 5; k++) begin
                @(negedge clk);
                got5[4-k] = bus2.serialOut;
            end
            check("p2 frame", 32'(got5), 32'(exp5));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
